// File: rtl/falloc_core_if.sv
// Client and header-LSU signal bundle for the free-list allocator core.
// Signal names carry the direction as seen from the core; the slave modport
// is the core side, the master modport is the client/LSU environment side.
interface falloc_core_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_op_i;
  logic [ADDR_W-1:0] req_size_i;
  logic [ADDR_W-1:0] req_ptr_i;
  logic              rsp_valid_o;
  logic [ADDR_W-1:0] rsp_ptr_o;
  logic              rsp_err_o;
  logic              lsu_req_valid_o;
  logic              lsu_req_ready_i;
  logic [1:0]        lsu_req_op_o;
  logic [ADDR_W-1:0] lsu_req_addr_o;
  logic [ADDR_W-1:0] lsu_req_size_o;
  logic [ADDR_W-1:0] lsu_req_next_o;
  logic              lsu_rsp_valid_i;
  logic [ADDR_W-1:0] lsu_rsp_size_i;
  logic [ADDR_W-1:0] lsu_rsp_next_i;

  modport slave (
    input  req_valid_i, req_op_i, req_size_i, req_ptr_i,
    input  lsu_req_ready_i, lsu_rsp_valid_i, lsu_rsp_size_i, lsu_rsp_next_i,
    output req_ready_o, rsp_valid_o, rsp_ptr_o, rsp_err_o,
    output lsu_req_valid_o, lsu_req_op_o, lsu_req_addr_o, lsu_req_size_o, lsu_req_next_o
  );

  modport master (
    output req_valid_i, req_op_i, req_size_i, req_ptr_i,
    output lsu_req_ready_i, lsu_rsp_valid_i, lsu_rsp_size_i, lsu_rsp_next_i,
    input  req_ready_o, rsp_valid_o, rsp_ptr_o, rsp_err_o,
    input  lsu_req_valid_o, lsu_req_op_o, lsu_req_addr_o, lsu_req_size_o, lsu_req_next_o
  );
endinterface

// File: rtl/falloc_core.sv
// First-fit free-list allocator core.
// ALLOC walks the singly linked free list from the sentinel header and carves
// the first block large enough, splitting off the tail when the remainder can
// hold a header plus a minimum payload. FREE pushes a block back at the head.
// Every list access is bracketed by LOCK/UNLOCK on the header LSU, and a hop
// watchdog bounds the walk so a corrupted (circular) list cannot hang the core.
module falloc_core #(
  parameter int                ADDR_W     = 32,
  parameter int                HDR_BYTES  = 16,
  parameter int                ALIGN_LOG2 = 3,
  parameter int                MIN_SPLIT  = 16,
  parameter logic [ADDR_W-1:0] HEAD_ADDR  = 'h10,
  parameter logic [ADDR_W-1:0] NULL_ADDR  = '0,
  parameter int                MAX_HOPS   = 1024
) (
  input logic          clk_i,
  input logic          rst_i,
  falloc_core_if.slave bus
);

  localparam int                HOP_W      = $clog2(MAX_HOPS + 1);
  localparam logic [ADDR_W-1:0] HDR        = ADDR_W'(HDR_BYTES);
  localparam logic [ADDR_W-1:0] SPLIT_MIN  = ADDR_W'(HDR_BYTES + MIN_SPLIT);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_LOG2) - 1);
  localparam logic [HOP_W-1:0]  HOP_LIMIT  = HOP_W'(MAX_HOPS);

  localparam logic [1:0] OP_LOCK   = 2'd0;
  localparam logic [1:0] OP_UNLOCK = 2'd1;
  localparam logic [1:0] OP_LOAD   = 2'd2;
  localparam logic [1:0] OP_STORE  = 2'd3;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOCK    = 4'd1;
  localparam logic [3:0] S_LD_HEAD = 4'd2;
  localparam logic [3:0] S_WALK    = 4'd3;
  localparam logic [3:0] S_LD_BLK  = 4'd4;
  localparam logic [3:0] S_FIT     = 4'd5;
  localparam logic [3:0] S_ST_NEW  = 4'd6;
  localparam logic [3:0] S_ST_PREV = 4'd7;
  localparam logic [3:0] S_UNLOCK  = 4'd8;
  localparam logic [3:0] S_RESP    = 4'd9;

  logic [3:0]        state;
  logic              lsu_acc;
  logic              is_free;
  logic              err_q;
  logic [ADDR_W-1:0] size_q;
  logic [ADDR_W-1:0] blk_q;
  logic [ADDR_W-1:0] prev_q;
  logic [ADDR_W-1:0] prev_size_q;
  logic [ADDR_W-1:0] cand_q;
  logic [ADDR_W-1:0] blk_size_q;
  logic [ADDR_W-1:0] blk_next_q;
  logic [ADDR_W-1:0] new_addr_q;
  logic [ADDR_W-1:0] new_size_q;
  logic [ADDR_W-1:0] new_next_q;
  logic [ADDR_W-1:0] link_q;
  logic [ADDR_W-1:0] rsp_ptr_q;
  logic [HOP_W-1:0]  hops_q;

  logic [ADDR_W:0]   size_sum;
  logic [ADDR_W-1:0] size_rounded;
  logic              imm_err;
  logic              lsu_state;
  logic              lsu_req_valid;
  logic              lsu_done;
  logic [ADDR_W-1:0] fit_diff;
  logic [ADDR_W-1:0] split_addr;

  // Request decode: round the size up to the alignment granule, watching the carry for wrap.
  always_comb begin
    size_sum     = {1'b0, bus.req_size_i} + {1'b0, ALIGN_MASK};
    size_rounded = size_sum[ADDR_W-1:0] & ~ALIGN_MASK;
    imm_err      = size_sum[ADDR_W] || (size_rounded == '0) ||
                   (bus.req_op_i && (bus.req_ptr_i < HDR));
  end

  // LSU handshake: request is up until accepted, done when the matching response arrives
  // (a response in the acceptance cycle itself also counts).
  always_comb begin
    lsu_state = (state == S_LOCK) || (state == S_LD_HEAD) || (state == S_LD_BLK) ||
                (state == S_ST_NEW) || (state == S_ST_PREV) || (state == S_UNLOCK);
    lsu_req_valid = lsu_state && !lsu_acc;
    lsu_done      = lsu_state && bus.lsu_rsp_valid_i && (lsu_acc || bus.lsu_req_ready_i);
    fit_diff      = blk_size_q - size_q;
    split_addr    = cand_q + HDR + size_q;
  end

  // LSU request fields, driven from registered state so they stay stable while stalled.
  always_comb begin
    bus.lsu_req_op_o   = OP_LOCK;
    bus.lsu_req_addr_o = '0;
    bus.lsu_req_size_o = '0;
    bus.lsu_req_next_o = '0;
    if (lsu_req_valid) begin
      case (state)
        S_LOCK: begin
          bus.lsu_req_op_o   = OP_LOCK;
          bus.lsu_req_addr_o = HEAD_ADDR;
        end
        S_LD_HEAD: begin
          bus.lsu_req_op_o   = OP_LOAD;
          bus.lsu_req_addr_o = HEAD_ADDR;
        end
        S_LD_BLK: begin
          bus.lsu_req_op_o   = OP_LOAD;
          bus.lsu_req_addr_o = cand_q;
        end
        S_ST_NEW: begin
          bus.lsu_req_op_o   = OP_STORE;
          bus.lsu_req_addr_o = new_addr_q;
          bus.lsu_req_size_o = new_size_q;
          bus.lsu_req_next_o = new_next_q;
        end
        S_ST_PREV: begin
          bus.lsu_req_op_o   = OP_STORE;
          bus.lsu_req_addr_o = prev_q;
          bus.lsu_req_size_o = prev_size_q;
          bus.lsu_req_next_o = link_q;
        end
        S_UNLOCK: begin
          bus.lsu_req_op_o   = OP_UNLOCK;
          bus.lsu_req_addr_o = HEAD_ADDR;
        end
        default: bus.lsu_req_op_o = OP_LOCK;
      endcase
    end
  end

  // Client-facing outputs; response fields read as zero outside the single RESP cycle.
  always_comb begin
    bus.req_ready_o     = (state == S_IDLE);
    bus.rsp_valid_o     = (state == S_RESP);
    bus.rsp_ptr_o       = (state == S_RESP) ? rsp_ptr_q : '0;
    bus.rsp_err_o       = (state == S_RESP) ? err_q : 1'b0;
    bus.lsu_req_valid_o = lsu_req_valid;
  end

  // Main control: walk/edit the list, with immediate errors going straight to RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      lsu_acc     <= 1'b0;
      is_free     <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= '0;
      blk_q       <= '0;
      prev_q      <= '0;
      prev_size_q <= '0;
      cand_q      <= '0;
      blk_size_q  <= '0;
      blk_next_q  <= '0;
      new_addr_q  <= '0;
      new_size_q  <= '0;
      new_next_q  <= '0;
      link_q      <= '0;
      rsp_ptr_q   <= '0;
      hops_q      <= '0;
    end else begin
      if (lsu_done) begin
        lsu_acc <= 1'b0;
      end else if (lsu_req_valid && bus.lsu_req_ready_i) begin
        lsu_acc <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            is_free   <= bus.req_op_i;
            size_q    <= size_rounded;
            blk_q     <= bus.req_ptr_i - HDR;
            rsp_ptr_q <= '0;
            err_q     <= imm_err;
            state     <= imm_err ? S_RESP : S_LOCK;
          end
        end
        S_LOCK: begin
          if (lsu_done) state <= S_LD_HEAD;
        end
        S_LD_HEAD: begin
          if (lsu_done) begin
            prev_q      <= HEAD_ADDR;
            prev_size_q <= '0;
            if (is_free) begin
              new_addr_q <= blk_q;
              new_size_q <= size_q;
              new_next_q <= bus.lsu_rsp_next_i;
              state      <= S_ST_NEW;
            end else begin
              cand_q <= bus.lsu_rsp_next_i;
              hops_q <= '0;
              state  <= S_WALK;
            end
          end
        end
        S_WALK: begin
          if ((cand_q == NULL_ADDR) || (hops_q == HOP_LIMIT)) begin
            err_q <= 1'b1;
            state <= S_UNLOCK;
          end else begin
            state <= S_LD_BLK;
          end
        end
        S_LD_BLK: begin
          if (lsu_done) begin
            blk_size_q <= bus.lsu_rsp_size_i;
            blk_next_q <= bus.lsu_rsp_next_i;
            state      <= S_FIT;
          end
        end
        S_FIT: begin
          if (blk_size_q < size_q) begin
            prev_q      <= cand_q;
            prev_size_q <= blk_size_q;
            cand_q      <= blk_next_q;
            hops_q      <= hops_q + HOP_W'(1);
            state       <= S_WALK;
          end else if (fit_diff >= SPLIT_MIN) begin
            new_addr_q <= split_addr;
            new_size_q <= fit_diff - HDR;
            new_next_q <= blk_next_q;
            link_q     <= split_addr;
            state      <= S_ST_NEW;
          end else begin
            link_q <= blk_next_q;
            state  <= S_ST_PREV;
          end
        end
        S_ST_NEW: begin
          if (lsu_done) begin
            if (is_free) link_q <= blk_q;
            state <= S_ST_PREV;
          end
        end
        S_ST_PREV: begin
          if (lsu_done) state <= S_UNLOCK;
        end
        S_UNLOCK: begin
          if (lsu_done) begin
            rsp_ptr_q <= (err_q || is_free) ? '0 : (cand_q + HDR);
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
